// File: rtl/uart_baud_gen_if.sv
// Purpose: divisor/tick bundle between UART config logic, baud generator and TX/RX engines.
// Latency: none, wires only.
// Backpressure: none; ticks are free-running clock enables with no ready path.
//
// Signals:
//   dvsr    - divisor from config logic (rx_tick period is dvsr+1 clocks)
//   rx_tick - single-cycle oversampling tick
//   tx_tick - single-cycle bit tick, coincident with every OVERSAMPLE-th rx_tick
interface uart_baud_gen_if #(
    parameter int DVSR_W = 11
);
    logic [DVSR_W-1:0] dvsr;
    logic              rx_tick;
    logic              tx_tick;

    // master: config side drives the divisor and consumes the ticks
    modport master (
        output dvsr,
        input  rx_tick,
        input  tx_tick
    );

    // slave: the baud generator itself
    modport slave (
        input  dvsr,
        output rx_tick,
        output tx_tick
    );
endinterface

// File: rtl/uart_baud_gen.sv
// Purpose: programmable baud tick generator; rx_tick every dvsr+1 clocks, tx_tick every OVERSAMPLE rx_ticks.
// Latency: ticks are registered; a dvsr change is seen on the next edge's comparison.
// Backpressure: none; ticks are free-running and cannot be stalled.
//
// Ports:
//   clk   - system clock, rising edge
//   reset - asynchronous active-low reset (deassertion must be synchronised by the integrator)
//   bus   - uart_baud_gen_if.slave: dvsr in, rx_tick/tx_tick out
// DVSR_W must match the interface instance's DVSR_W. OVERSAMPLE must be a power of two >= 2.
module uart_baud_gen #(
    parameter int DVSR_W     = 11,
    parameter int OVERSAMPLE = 16
) (
    input  logic            clk,
    input  logic            reset,
    uart_baud_gen_if.slave  bus
);
    localparam int TX_W = $clog2(OVERSAMPLE);
    localparam logic [TX_W-1:0] TX_LAST = TX_W'(OVERSAMPLE - 1);

    logic [DVSR_W-1:0] rx_cnt;
    logic [TX_W-1:0]   tx_cnt;
    logic              rx_tick_q;
    logic              tx_tick_q;
    logic              rx_wrap;

    // ">=" rather than "==" so that lowering dvsr below the running count
    // wraps on the next edge instead of counting through 2^DVSR_W.
    assign rx_wrap = (rx_cnt >= bus.dvsr);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rx_cnt    <= '0;
            tx_cnt    <= '0;
            rx_tick_q <= 1'b0;
            tx_tick_q <= 1'b0;
        end else begin
            if (rx_wrap) begin
                rx_cnt    <= '0;
                rx_tick_q <= 1'b1;
                // tx divider only advances on the rx wrap edge, so tx_tick
                // can only ever rise together with rx_tick.
                if (tx_cnt == TX_LAST) begin
                    tx_cnt    <= '0;
                    tx_tick_q <= 1'b1;
                end else begin
                    tx_cnt    <= tx_cnt + TX_W'(1);
                    tx_tick_q <= 1'b0;
                end
            end else begin
                // rx_cnt < dvsr here, so the increment cannot overflow.
                rx_cnt    <= rx_cnt + DVSR_W'(1);
                rx_tick_q <= 1'b0;
                tx_tick_q <= 1'b0;
            end
        end
    end

    assign bus.rx_tick = rx_tick_q;
    assign bus.tx_tick = tx_tick_q;
endmodule

// File: tb/tb_uart_baud_gen.sv
// Purpose: self-checking bench for uart_baud_gen against an elapsed-time tick model.
// Latency: n/a.
// Backpressure: n/a.
module tb_uart_baud_gen;
    localparam int DVSR_W = 11;
    localparam int OS     = 16;

    logic clk;
    logic reset;

    uart_baud_gen_if #(.DVSR_W(DVSR_W)) bus ();

    uart_baud_gen #(.DVSR_W(DVSR_W), .OVERSAMPLE(OS)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    // Reference model: clocks elapsed since the last rx tick, and total rx
    // ticks since reset; tx fires on every OS-th rx tick.
    int since_rx;
    int n_rx;
    int k_edge;
    int exp_rx;
    int exp_tx;

    task automatic check_eq(input string tag, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d (edge %0d, t=%0t)", tag, act, exp, k_edge, $time);
        end
    endtask

    task automatic model_reset();
        since_rx = 0;
        n_rx     = 0;
        k_edge   = 0;
        exp_rx   = 0;
        exp_tx   = 0;
    endtask

    // One rising edge; model uses the divisor present at the edge, outputs sampled 1 time unit later.
    task automatic tick_edge();
        int d;
        @(posedge clk);
        d = int'(bus.dvsr);
        if (reset) begin
            k_edge++;
            if (since_rx >= d) begin
                since_rx = 0;
                n_rx++;
                exp_rx = 1;
                exp_tx = (n_rx % OS == 0) ? 1 : 0;
            end else begin
                since_rx++;
                exp_rx = 0;
                exp_tx = 0;
            end
        end
        #1;
        check_eq("rx_tick", int'(bus.rx_tick), exp_rx);
        check_eq("tx_tick", int'(bus.tx_tick), exp_tx);
    endtask

    // Called at posedge+1: drop reset mid-cycle and confirm outputs clear with no edge.
    task automatic assert_reset_async();
        #1 reset = 1'b0;
        #1;
        model_reset();
        check_eq("async_rx", int'(bus.rx_tick), 0);
        check_eq("async_tx", int'(bus.tx_tick), 0);
    endtask

    // Called at posedge+1: release reset so the next rising edge is edge 1.
    task automatic release_reset();
        #2 reset = 1'b1;
    endtask

    initial begin
        int d;
        int gap;
        int run;
        int chg;

        reset    = 1'b0;
        bus.dvsr = DVSR_W'(2);
        model_reset();

        // Reset held: both ticks stay low.
        repeat (5) tick_edge();
        check_eq("rst_hold_rx", int'(bus.rx_tick), 0);

        // Nominal divide, dvsr=2: rx on edges 3,6,9..; tx on 48,96.
        release_reset();
        repeat (102) begin
            tick_edge();
            check_eq("nom_rx", int'(bus.rx_tick), (k_edge % 3 == 0) ? 1 : 0);
            check_eq("nom_tx", int'(bus.tx_tick), (k_edge % 48 == 0) ? 1 : 0);
        end
        // Edge 102 produced an rx tick; reset must kill it without a clock edge.
        check_eq("pre_async_rx", int'(bus.rx_tick), 1);
        assert_reset_async();

        // Zero divisor: rx every cycle, tx every 16th.
        bus.dvsr = '0;
        repeat (2) tick_edge();
        release_reset();
        repeat (40) begin
            tick_edge();
            check_eq("zero_rx", int'(bus.rx_tick), 1);
            check_eq("zero_tx", int'(bus.tx_tick), (k_edge % 16 == 0) ? 1 : 0);
        end

        // Divisor shrink: dvsr=10, first rx at edge 11, count reaches 7 at edge 18.
        assert_reset_async();
        bus.dvsr = DVSR_W'(10);
        tick_edge();
        release_reset();
        repeat (18) begin
            tick_edge();
            check_eq("shrink_pre_rx", int'(bus.rx_tick), (k_edge == 11) ? 1 : 0);
        end
        bus.dvsr = DVSR_W'(3);
        tick_edge();
        check_eq("shrink_next_rx", int'(bus.rx_tick), 1);
        // Then period 4; tx after 16 rx ticks total (2 already) -> 14 more = 56 edges.
        repeat (56) begin
            tick_edge();
            check_eq("shrink_rx", int'(bus.rx_tick), (k_edge % 4 == 3) ? 1 : 0);
            check_eq("shrink_tx", int'(bus.tx_tick), (k_edge == 75) ? 1 : 0);
        end
        repeat (100) tick_edge();

        // Reset after 20 rx ticks; next tx must be 48 edges after release.
        assert_reset_async();
        bus.dvsr = DVSR_W'(2);
        tick_edge();
        release_reset();
        repeat (60) tick_edge();
        check_eq("mid_rx_count", n_rx, 20);
        assert_reset_async();
        repeat (2) tick_edge();
        release_reset();
        gap = 0;
        for (int i = 0; i < 200; i++) begin
            tick_edge();
            if (bus.tx_tick && gap == 0) gap = k_edge;
        end
        check_eq("rst_tx_gap", gap, 48);

        // Max divisor: rx period 2048, tx period 32768.
        assert_reset_async();
        bus.dvsr = DVSR_W'(2047);
        tick_edge();
        release_reset();
        repeat (32768 + 2048 + 4) begin
            tick_edge();
            if (bus.rx_tick || bus.tx_tick || (k_edge % 2048 == 0)) begin
                check_eq("max_rx", int'(bus.rx_tick), (k_edge % 2048 == 0) ? 1 : 0);
                check_eq("max_tx", int'(bus.tx_tick), (k_edge % 32768 == 0) ? 1 : 0);
            end
        end
        check_eq("max_rx_count", n_rx, 17);

        // Randomized segments: random divisors, mid-run changes and resets.
        for (int s = 0; s < 30; s++) begin
            if ($urandom_range(0, 3) == 0) begin
                assert_reset_async();
                tick_edge();
                release_reset();
            end
            d   = $urandom_range(0, 20);
            bus.dvsr = DVSR_W'(d);
            run = $urandom_range(50, 300);
            chg = $urandom_range(1, run - 1);
            for (int i = 0; i < run; i++) begin
                tick_edge();
                if (i == chg) bus.dvsr = DVSR_W'($urandom_range(0, 20));
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
